// File: rtl/caq_tape_pkg.sv
// caq_tape_pkg: shared state type, default bit timing and sizing helper for
// the CAQ cassette playback engine.
package caq_tape_pkg;

   // Default bit-cell timing, in ce_tape ticks per half period.
   localparam int T1_HALF   = 1;
   localparam int T0_HALF   = 2;
   // Default number of '1' stop bits appended after every byte.
   localparam int STOP_BITS = 2;

   // Byte-level playback states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5,
      ST_DONE  = 3'd6
   } tape_state_t;

   // Width of a tick counter that must hold a full bit cell (2 * longest half).
   function automatic int tick_cnt_width(input int t0, input int t1);
      int m;
      m = (t0 > t1) ? t0 : t1;
      return $clog2(2 * m + 1);
   endfunction

endpackage

// File: rtl/caq_tape_player_if.sv
// caq_tape_player_if: image loader and tape RAM read port seen by the player.
//
// Protocol: 'loaded' is a one-clk pulse that marks a finished download; 'length'
// is only meaningful in that clk. 'addr' is driven by the player and 'data'
// returns the RAM byte at that address one clk after 'addr' changes. There is
// no back-pressure: the RAM always answers, so no valid/ready pair is needed.
interface caq_tape_player_if;
   logic        loaded;
   logic [15:0] length;
   logic [15:0] addr;
   logic [7:0]  data;

   // Player side: consumes loader/RAM signals, drives the read address.
   modport master (
      input  loaded,
      input  length,
      input  data,
      output addr
   );

   // Loader/RAM side.
   modport slave (
      output loaded,
      output length,
      output data,
      input  addr
   );
endinterface

// File: rtl/tape_bit_gen.sv
// tape_bit_gen: produces one cassette bit cell. The level goes high on the
// first ce_tape tick of the cell, falls after 'half' ticks and the cell ends
// after 2*half ticks. A start presented on the final tick chains the next cell
// without losing a tick, so consecutive cells are seamless.
module tape_bit_gen #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ce_tape,
   input  logic          clear,
   input  logic          start,
   input  logic          bit_val,
   input  logic [CW-1:0] half_one,
   input  logic [CW-1:0] half_zero,
   output logic          level,
   output logic          done
);

   logic          active;
   logic [CW-1:0] cnt;
   logic [CW-1:0] half_q;
   logic [CW-1:0] half_sel;
   logic [CW-1:0] last_cnt;

   assign half_sel = bit_val ? half_one : half_zero;
   assign last_cnt = (half_q << 1) - CW'(1);

   // Final tick of the current cell; the caller may chain a new cell on it.
   assign done = active & ce_tape & (cnt == last_cnt);

   // Tick counter and output level; clear aborts the cell and discards any tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active <= 1'b0;
         cnt    <= '0;
         half_q <= '0;
         level  <= 1'b0;
      end else if (clear) begin
         active <= 1'b0;
         cnt    <= '0;
         half_q <= '0;
         level  <= 1'b0;
      end else if (active && ce_tape) begin
         // Tick k (1-based) of the cell is high while k <= half.
         level <= (cnt < half_q);
         if (cnt == last_cnt) begin
            cnt    <= '0;
            active <= start;
            if (start) begin
               half_q <= half_sel;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else if (start) begin
         // Arming from idle: a coincident tick belongs to the latch clk, not the cell.
         active <= 1'b1;
         cnt    <= '0;
         half_q <= half_sel;
      end
   end

endmodule

// File: rtl/caq_tape_player.sv
// caq_tape_player: reads a loaded CAQ image byte by byte from the tape RAM and
// serialises it as start bit, 8 data bits MSB first and stop bits on 'out'.
// The next byte is prefetched during the stop bits so frames run back to back.
module caq_tape_player
   import caq_tape_pkg::*;
#(
   parameter int T1_HALF   = caq_tape_pkg::T1_HALF,
   parameter int T0_HALF   = caq_tape_pkg::T0_HALF,
   parameter int STOP_BITS = caq_tape_pkg::STOP_BITS
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce_tape,
   caq_tape_player_if.master tape,
   output logic              req,
   output logic              out,
   output tape_state_t       dbg_state
);

   localparam int CW = tick_cnt_width(T0_HALF, T1_HALF);
   localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

   localparam logic [CW-1:0] HALF_ONE  = CW'(T1_HALF);
   localparam logic [CW-1:0] HALF_ZERO = CW'(T0_HALF);
   localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

   tape_state_t   state;
   logic [15:0]   addr_q;     // also the count of bytes already latched
   logic [15:0]   len_q;      // image length captured at the loaded pulse
   logic [7:0]    shreg;      // byte being shifted out, MSB first
   logic [7:0]    nxt_byte;   // prefetched byte for the following frame
   logic          pf_valid;
   logic [2:0]    bit_idx;
   logic [SW-1:0] stop_idx;

   logic          cell_start;
   logic          cell_bit;
   logic          cell_done;
   logic          level;

   assign tape.addr = addr_q;
   assign out       = level;
   assign dbg_state = state;

   // Decide when the bit generator begins the next cell and with which value.
   always_comb begin
      cell_start = 1'b0;
      cell_bit   = 1'b0;
      if (!tape.loaded) begin
         case (state)
            ST_LOAD: begin
               cell_start = 1'b1;
               cell_bit   = 1'b0;
            end
            ST_START: begin
               if (cell_done) begin
                  cell_start = 1'b1;
                  cell_bit   = shreg[7];
               end
            end
            ST_DATA: begin
               if (cell_done) begin
                  cell_start = 1'b1;
                  cell_bit   = (bit_idx == 3'd7) ? 1'b1 : shreg[6];
               end
            end
            ST_STOP: begin
               if (cell_done) begin
                  if (stop_idx != STOP_LAST) begin
                     cell_start = 1'b1;
                     cell_bit   = 1'b1;
                  end else if (pf_valid) begin
                     cell_start = 1'b1;
                     cell_bit   = 1'b0;
                  end
               end
            end
            default: begin
               cell_start = 1'b0;
               cell_bit   = 1'b0;
            end
         endcase
      end
   end

   // Byte sequencer: fetch, latch, frame the byte and prefetch the next one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         shreg    <= '0;
         nxt_byte <= '0;
         pf_valid <= 1'b0;
         bit_idx  <= '0;
         stop_idx <= '0;
         req      <= 1'b0;
      end else if (tape.loaded) begin
         // A new image always restarts from byte 0, even mid-playback.
         len_q    <= tape.length;
         addr_q   <= '0;
         pf_valid <= 1'b0;
         bit_idx  <= '0;
         stop_idx <= '0;
         if (tape.length != 16'd0) begin
            state <= ST_FETCH;
            req   <= 1'b1;
         end else begin
            state <= ST_IDLE;
            req   <= 1'b0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               req <= 1'b0;
            end
            ST_FETCH: begin
               // RAM answers one clk after the address was set.
               state <= ST_LOAD;
            end
            ST_LOAD: begin
               shreg  <= tape.data;
               addr_q <= addr_q + 16'd1;
               state  <= ST_START;
            end
            ST_START: begin
               if (cell_done) begin
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (cell_done) begin
                  shreg   <= shreg << 1;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     stop_idx <= '0;
                     state    <= ST_STOP;
                  end
               end
            end
            ST_STOP: begin
               // The address has been stable since the previous latch, so the
               // RAM word is already valid on the first stop clk.
               if (!pf_valid && (addr_q != len_q)) begin
                  nxt_byte <= tape.data;
                  addr_q   <= addr_q + 16'd1;
                  pf_valid <= 1'b1;
               end
               if (cell_done) begin
                  if (stop_idx != STOP_LAST) begin
                     stop_idx <= stop_idx + SW'(1);
                  end else if (pf_valid) begin
                     shreg    <= nxt_byte;
                     pf_valid <= 1'b0;
                     stop_idx <= '0;
                     state    <= ST_START;
                  end else begin
                     req   <= 1'b0;
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               req   <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               req   <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   tape_bit_gen #(
      .CW(CW)
   ) u_bit_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce_tape   (ce_tape),
      .clear     (tape.loaded),
      .start     (cell_start),
      .bit_val   (cell_bit),
      .half_one  (HALF_ONE),
      .half_zero (HALF_ZERO),
      .level     (level),
      .done      (cell_done)
   );

endmodule
